// File: rtl/therm_dec_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | therm_dec_pkg: shared sizing and clamp helpers for the thermometer   |
// | decoder.  Rev 1.0                                                    |
// +-----------------------------------------------------------------------+
package therm_dec_pkg;

  // Serial code width needed to express every level 0..d_w.
  function automatic int cw_of(input int d_w);
    return $clog2(d_w + 1);
  endfunction

  function automatic int sat_code(input int code, input int d_w);
    return (code > d_w) ? d_w : code;
  endfunction

endpackage : therm_dec_pkg
`default_nettype wire

// File: rtl/serial_thermometer_decoder_bin2therm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bin2therm: combinational binary-to-thermometer converter; over-range |
// | codes saturate to all ones.  Rev 1.0                                 |
// +-----------------------------------------------------------------------+
module bin2therm
  import therm_dec_pkg::*;
#(
  parameter int D_W = 8,
  parameter int CW  = cw_of(D_W)
) (
  input  logic [CW-1:0]  code,
  output logic [D_W-1:0] therm
);

  int w_level;

  always_comb begin
    w_level = sat_code(int'(32'(code)), D_W);
    therm   = '0;
    for (int i = 0; i < D_W; i++) begin
      therm[i] = (i < w_level);
    end
  end

endmodule : bin2therm
`default_nettype wire

// File: rtl/serial_thermometer_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_thermometer_decoder: deserialises free-running CW-bit frames   |
// | and registers their thermometer code.  THERM_DEC_LSB_FIRST_EN selects |
// | LSB-first framing (default MSB-first).  Rev 1.0                       |
// +-----------------------------------------------------------------------+
module serial_thermometer_decoder
  import therm_dec_pkg::*;
#(
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           serial_in,
  output logic [D_W-1:0] thermometer_out
);

  localparam int CW = cw_of(D_W);
  localparam int c_cnt_w = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CW - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [CW-1:0]      w_code;
  logic               w_last;
  logic [D_W-1:0]     w_therm;
  logic [D_W-1:0]     r_therm;

  assign w_last = (r_cnt == c_last);

  // Only the CW-1 bits that survive into the next code are stored; the
  // current serial_in completes the code combinationally.
  generate
    if (CW == 1) begin : g_single
      assign w_code = serial_in;
    end else begin : g_multi
      logic [CW-2:0] r_hist;
`ifdef THERM_DEC_LSB_FIRST_EN
      assign w_code = {serial_in, r_hist};
`else
      assign w_code = {r_hist, serial_in};
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hist <= '0;
        end else begin
`ifdef THERM_DEC_LSB_FIRST_EN
          r_hist <= w_code[CW-1:1];
`else
          r_hist <= w_code[CW-2:0];
`endif
        end
      end
    end
  endgenerate

  bin2therm #(
    .D_W (D_W),
    .CW  (CW)
  ) u_bin2therm (
    .code  (w_code),
    .therm (w_therm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_therm <= '0;
    end else begin
      r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
      if (w_last) begin
        r_therm <= w_therm;
      end
    end
  end

  assign thermometer_out = r_therm;

endmodule : serial_thermometer_decoder
`default_nettype wire

// File: tb/tb_serial_thermometer_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serial_thermometer_decoder: scoreboard bench with an arithmetic    |
// | reference model of the serial thermometer decoder.  Rev 1.0           |
// +-----------------------------------------------------------------------+
module tb_serial_thermometer_decoder;

  localparam int D_W = 8;
  localparam int CW  = $clog2(D_W + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           serial_in = 1'b0;
  logic [D_W-1:0] thermometer_out;

  int errors = 0;
  int checks = 0;

  logic [D_W-1:0] exp_q[$];
  int             m_pos;
  int             m_code;
  logic [D_W-1:0] m_out;

  always #5 clk = ~clk;

  serial_thermometer_decoder #(.D_W(D_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .serial_in       (serial_in),
    .thermometer_out (thermometer_out)
  );

  function automatic logic [D_W-1:0] therm_of(input int n);
    int lvl;
    lvl = (n > D_W) ? D_W : n;
    return D_W'((64'd1 << lvl) - 64'd1);
  endfunction

  task automatic check(input string name, input logic [D_W-1:0] act,
                       input logic [D_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos  = 0;
    m_code = 0;
    m_out  = '0;
  endfunction

  // Frame position and accumulated code value, in plain integers.
  function automatic void model_step(input logic b);
`ifdef THERM_DEC_LSB_FIRST_EN
    m_code = m_code + (int'(b) << m_pos);
`else
    m_code = m_code * 2 + int'(b);
`endif
    m_pos++;
    if (m_pos == CW) begin
      m_out  = therm_of(m_code);
      m_pos  = 0;
      m_code = 0;
    end
  endfunction

  // One clock: drive on the falling edge, predict on the rising edge.
  task automatic cycle(input logic b);
    @(negedge clk);
    serial_in = b;
    @(posedge clk);
    if (rst_n) model_step(b);
    else       model_reset();
    exp_q.push_back(m_out);
  endtask

  task automatic send_code(input int k);
    for (int i = 0; i < CW; i++) begin
`ifdef THERM_DEC_LSB_FIRST_EN
      cycle(1'((k >> i) & 1));
`else
      cycle(1'((k >> (CW - 1 - i)) & 1));
`endif
    end
  endtask

  task automatic send_bits4(input logic b0, input logic b1, input logic b2,
                            input logic b3);
    cycle(b0);
    cycle(b1);
    cycle(b2);
    cycle(b3);
  endtask

  // Called just after a rising edge: assert reset between edges, release
  // it before the next falling edge after `hold` clocks in reset.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("async_clear", thermometer_out, '0);
    repeat (hold) cycle(1'($urandom));
    #3;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("scoreboard", thermometer_out, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (4) cycle(1'($urandom));
    #1;
    check("reset_hold", thermometer_out, '0);
    #2;
    rst_n = 1'b1;

    send_bits4(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef THERM_DEC_LSB_FIRST_EN
    check("frame_1010", thermometer_out, 8'h1F);
`else
    check("frame_1010", thermometer_out, 8'hFF);
`endif

    send_bits4(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("zero_frame", thermometer_out, 8'h00);
    repeat (2 * CW) cycle(1'b0);

    for (int k = 0; k < 16; k++) begin
      send_code(k);
      #1;
      check("exhaustive", thermometer_out, (k >= D_W) ? 8'hFF : 8'((1 << k) - 1));
    end

    cycle(1'b0);
    cycle(1'b1);
    async_reset(2);
    send_bits4(1'b0, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef THERM_DEC_LSB_FIRST_EN
    check("midframe_reset", thermometer_out, 8'hFF);
`else
    check("midframe_reset", thermometer_out, 8'h1F);
`endif

    send_bits4(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef THERM_DEC_LSB_FIRST_EN
    check("bits_1100", thermometer_out, 8'h07);
`else
    check("bits_1100", thermometer_out, 8'hFF);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) async_reset($urandom_range(1, 3));
      else cycle(1'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_thermometer_decoder
`default_nettype wire

// File: doc/serial_thermometer_decoder.md
Name: serial_thermometer_decoder

Overview:
- Deserialises a fixed-length binary code from a single-bit serial input, one bit per clock.
- Converts the completed code to a D_W-bit thermometer word that drives the unary/segmented DAC switch array.
- Sits between the serial control interface and the DAC segment drivers.
- Output is registered and holds its value between frames.

Parameters:
- D_W, 8: thermometer output width; the number of unary segments. Legal range 1..255.
- CW (localparam), $clog2(D_W+1): serial code width in bits; 4 for D_W=8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial code bit, sampled on every rising clk edge while rst_n=1.
- thermometer_out  output  D_W  registered thermometer code; bit i=1 iff i < decoded value.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous assert, active-low, with synchronous-release semantics.
- Reset state: thermometer_out=0, shift register=0, bit counter=0.
- Framing: free-running frames of CW bits. The first frame starts at the first rising edge with rst_n=1, with no start bit or idle detection. The bit counter counts 0..CW-1 and wraps to 0 after the last bit, so frames are back-to-back.
- Bit order: MSB first by default.
- Shift: every edge, shift_reg <= {shift_reg[CW-2:0], serial_in}.
- Output update: on the edge where bit counter == CW-1, form code = {shift_reg[CW-2:0], serial_in}. Then thermometer_out <= therm(min(code, D_W)). This gives zero extra latency: the output changes on the same edge that samples the last bit.
- Saturation: codes greater than D_W clamp to all-ones. Example: D_W=8, code 10 gives 8'hFF.
- Mapping: code 0 gives all zeros; code k gives the lower k bits set; code D_W gives all ones.
- Hold: thermometer_out is unchanged on edges that are not the last bit of a frame.
- Reset mid-frame: partial frame discarded, counter returns to 0, output cleared. After release, framing restarts at bit 0.
- Invariant: thermometer_out is always a valid thermometer code (no bubbles). Only ones below zeros.
- Degenerate case: if CW==1 (D_W=1), every edge completes a frame and thermometer_out <= serial_in.

Optional Feature:
- Macro: THERM_DEC_LSB_FIRST_EN.
- Defined: the first serial bit of each frame is the LSB. The code is assembled by shifting right, i.e. code = {serial_in, shift_reg[CW-1:1]} at the frame's last bit. Everything else is unchanged.
- Undefined: MSB-first, as described in Behaviour.

Decomposition:
- Package therm_dec_pkg:
  - function cw_of(D_W) returning $clog2(D_W+1).
  - function sat_code(code, D_W) performing the clamp.
- One natural sub-module: bin2therm. It is purely combinational: CW-bit input, D_W-bit thermometer output, with saturation.
- The top level holds the shift register, bit counter and output register.

Test Plan:
- Reset: hold rst_n=0 with random serial_in, then check thermometer_out=8'h00. Assert rst_n=0 asynchronously between clock edges and check the output clears immediately.
- Over-range saturation: release reset, drive MSB-first bits 1,0,1,0 on four consecutive edges (code 10) -> thermometer_out=8'hFF after the 4th edge, held until the next frame completes.
- Zero frame: immediately following frame 0,0,0,0 -> thermometer_out=8'h00 on its 4th edge. Continued zeros keep it at 8'h00.
- Exhaustive: frames for codes 0..15 back-to-back:
  - code k<=8 -> lower k bits set (code 3 -> 8'h07, code 8 -> 8'hFF).
  - codes 9..15 -> 8'hFF.
  - No output change on non-final bits of any frame.
- Mid-frame reset: send 2 bits of code 0101, pulse rst_n low, then send full frame 0,1,0,1 -> 8'h1F. Stale bits must not leak into the result.
- With THERM_DEC_LSB_FIRST_EN defined: serial bits 1,1,0,0 (code 3) -> 8'h07. Without the macro, the same bits (code 12) -> 8'hFF.
